// File: rtl/datapath_pkg.sv
// Shared definitions for the arithmetic datapath and its request scheduler.
package datapath_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDC = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_DEC  = 3'b110;

  // Width of a requester index; never collapses to zero bits.
  function automatic int id_w(input int r);
    return (r < 2) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr, ptr advances past the winner.
module rr_arbiter
  import datapath_pkg::*;
#(
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [R-1:0]         req,
  input  logic                 en,
  output logic [R-1:0]         gnt,
  output logic [id_w(R)-1:0]   gnt_id,
  output logic                 gnt_any
);

  localparam int             IW   = id_w(R);
  localparam logic [IW-1:0]  LAST = IW'(R - 1);

  logic [IW-1:0] ptr;
  int            idx;

  // Scan from farthest to nearest so the requester closest to ptr overwrites the rest.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (en) begin
      for (int k = R - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= R) idx = idx - R;
        if (req[idx[IW-1:0]]) begin
          gnt_id  = idx[IW-1:0];
          gnt_any = 1'b1;
        end
      end
      if (gnt_any) gnt[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (gnt_any) ptr <= (gnt_id == LAST) ? '0 : gnt_id + IW'(1);
  end

endmodule

// File: rtl/datapath_arbiter.sv
// Shares one add/sub datapath among R requesters: round-robin issue, latency-matched tag pipe, result return.
module datapath_arbiter
  import datapath_pkg::*;
#(
  parameter int N   = 16,
  parameter int R   = 4,
  parameter int LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [R-1:0]        req_valid,
  output logic [R-1:0]        req_ready,
  input  logic [R*N-1:0]      req_A,
  input  logic [R*N-1:0]      req_B,
  input  logic [R*3-1:0]      req_opcode,
  output logic [N-1:0]        dp_A,
  output logic [N-1:0]        dp_B,
  output logic [2:0]          dp_opcode,
  input  logic [N-1:0]        dp_Y,
  input  logic                dp_co,
  output logic [R-1:0]        rsp_valid,
  output logic [N-1:0]        rsp_Y,
  output logic                rsp_co,
  output logic [id_w(R)-1:0]  rsp_id,
  output logic                idle
);

  localparam int IW = id_w(R);

  logic [IW-1:0] gnt_id;
  logic          gnt_any;

  rr_arbiter #(.R(R)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (en),
    .gnt     (req_ready),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Operand registers hold on idle cycles so the datapath inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_A      <= '0;
      dp_B      <= '0;
      dp_opcode <= OP_ADD;
    end else if (gnt_any) begin
      dp_A      <= req_A[gnt_id*N +: N];
      dp_B      <= req_B[gnt_id*N +: N];
      dp_opcode <= req_opcode[gnt_id*3 +: 3];
    end
  end

  // Stage 0 is the issue stage itself; stage LAT lines up with dp_Y.
  logic [LAT:0]          vld_pipe;
  logic [LAT:0][IW-1:0]  id_pipe;

  generate
    if (LAT == 0) begin : g_tag_wire
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          id_pipe  <= '0;
        end else begin
          vld_pipe[0] <= gnt_any;
          if (gnt_any) id_pipe[0] <= gnt_id;
        end
      end
    end else begin : g_tag_pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          id_pipe  <= '0;
        end else begin
          vld_pipe <= {vld_pipe[LAT-1:0], gnt_any};
          id_pipe  <= {id_pipe[LAT-1:0], gnt_any ? gnt_id : id_pipe[0]};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_Y     <= '0;
      rsp_co    <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= '0;
      if (vld_pipe[LAT]) begin
        rsp_valid <= R'(1) << id_pipe[LAT];
        rsp_Y     <= dp_Y;
        rsp_co    <= dp_co;
        rsp_id    <= id_pipe[LAT];
      end
    end
  end

  assign idle = ~|vld_pipe;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Drives three arbiters (LAT 0,1,2) with shared stimulus; a cycle model checks every output each cycle.
module tb_datapath_arbiter;
  import datapath_pkg::*;

  localparam int N = 16, R = 4, NI = 3, IW = 2, MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, en;
  logic [R-1:0]      req_valid;
  logic [R*N-1:0]    req_A, req_B;
  logic [R*3-1:0]    req_opcode;

  logic [R-1:0]  rdy [NI];
  logic [N-1:0]  dpa [NI], dpb [NI], dpy [NI], ry [NI];
  logic [2:0]    dpo [NI];
  logic          dpc [NI], rc [NI], idl [NI];
  logic [R-1:0]  rv  [NI];
  logic [IW-1:0] rid [NI];

  int total = 0, bad = 0, cyc = 0;

  // Reference add/sub unit: B optionally zeroed, optionally inverted, plus carry-in.
  function automatic logic [N:0] calc(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    logic [N-1:0] bb;
    bb = op[2] ? '0 : b;
    if (op[1]) bb = ~bb;
    return {1'b0, a} + {1'b0, bb} + (N+1)'(op[0]);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    datapath_arbiter #(.N(N), .R(R), .LAT(g)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .req_valid(req_valid), .req_ready(rdy[g]),
      .req_A(req_A), .req_B(req_B), .req_opcode(req_opcode),
      .dp_A(dpa[g]), .dp_B(dpb[g]), .dp_opcode(dpo[g]),
      .dp_Y(dpy[g]), .dp_co(dpc[g]),
      .rsp_valid(rv[g]), .rsp_Y(ry[g]), .rsp_co(rc[g]), .rsp_id(rid[g]),
      .idle(idl[g])
    );
    logic [N:0] cur;
    logic [N:0] dly [0:1];
    assign cur = calc(dpa[g], dpb[g], dpo[g]);
    always @(posedge clk) begin
      dly[0] <= cur;
      dly[1] <= dly[0];
    end
    if (g == 0) begin : g_comb
      assign {dpc[g], dpy[g]} = cur;
    end else begin : g_reg
      assign {dpc[g], dpy[g]} = dly[g-1];
    end
  end

  // Model: grant log indexed by cycle; a grant at cycle n returns at n+2+LAT unless a reset intervened.
  int            ptr = 0, rst_mark = -1;
  logic          g_vld [MAXC];
  logic [IW-1:0] g_id  [MAXC];
  logic [N:0]    g_res [MAXC];
  logic [N-1:0]  e_dpa, e_dpb;
  logic [2:0]    e_dpo;
  logic [N-1:0]  e_ry  [NI];
  logic          e_rc  [NI];
  logic [IW-1:0] e_rid [NI];

  always @(negedge clk) begin
    logic [R-1:0] eg, erv;
    int w, n;
    logic busy;
    eg = '0;
    w  = -1;
    if (en)
      for (int k = 0; k < R; k++)
        if (w < 0 && req_valid[(ptr + k) % R]) w = (ptr + k) % R;
    if (w >= 0) eg[w] = 1'b1;
    if (!rst_n) begin
      ptr = 0; rst_mark = cyc; g_vld[cyc] = 1'b0;
      e_dpa = '0; e_dpb = '0; e_dpo = '0;
      for (int i = 0; i < NI; i++) begin
        e_ry[i] = '0; e_rc[i] = 1'b0; e_rid[i] = '0;
        chk("rst_ready", i, 32'(rdy[i]), 32'(eg));
        chk("rst_dp_A", i, 32'(dpa[i]), 32'(0));
        chk("rst_dp_op", i, 32'(dpo[i]), 32'(0));
        chk("rst_rsp_valid", i, 32'(rv[i]), 32'(0));
        chk("rst_rsp_Y", i, 32'(ry[i]), 32'(0));
        chk("rst_rsp_id", i, 32'(rid[i]), 32'(0));
        chk("rst_idle", i, 32'(idl[i]), 32'(1));
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        chk("req_ready", i, 32'(rdy[i]), 32'(eg));
        chk("dp_A", i, 32'(dpa[i]), 32'(e_dpa));
        chk("dp_B", i, 32'(dpb[i]), 32'(e_dpb));
        chk("dp_opcode", i, 32'(dpo[i]), 32'(e_dpo));
        n = cyc - 2 - i;
        erv = '0;
        if (n > rst_mark && g_vld[n]) begin
          erv = R'(1) << g_id[n];
          e_ry[i] = g_res[n][N-1:0]; e_rc[i] = g_res[n][N]; e_rid[i] = g_id[n];
        end
        chk("rsp_valid", i, 32'(rv[i]), 32'(erv));
        chk("rsp_Y", i, 32'(ry[i]), 32'(e_ry[i]));
        chk("rsp_co", i, 32'(rc[i]), 32'(e_rc[i]));
        chk("rsp_id", i, 32'(rid[i]), 32'(e_rid[i]));
        busy = 1'b0;
        for (int m = cyc - 1 - i; m <= cyc - 1; m++)
          if (m > rst_mark && g_vld[m]) busy = 1'b1;
        chk("idle", i, 32'(idl[i]), 32'(!busy));
      end
      g_vld[cyc] = (w >= 0);
      if (w >= 0) begin
        e_dpa = req_A[w*N +: N]; e_dpb = req_B[w*N +: N]; e_dpo = req_opcode[w*3 +: 3];
        g_id[cyc]  = IW'(w);
        g_res[cyc] = calc(e_dpa, e_dpb, e_dpo);
        ptr = (w + 1) % R;
      end
    end
    if (cyc < MAXC - 1) cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    req_A[r*N +: N] = a; req_B[r*N +: N] = b; req_opcode[r*3 +: 3] = op;
  endtask

  function automatic logic [N-1:0] rnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [R-1:0] fire;
    int pulses;
    rst_n = 1'b0; en = 1'b1; req_valid = '0; req_A = '0; req_B = '0; req_opcode = '0;
    tick(); tick();
    @(negedge clk);
    chk("lit_reset_idle", 2, 32'(idl[2]), 32'(1));
    tick(); rst_n = 1'b1;

    // single add on requester 2
    set_op(2, 16'd5, 16'd3, OP_ADD); req_valid = 4'b0100;
    @(negedge clk); chk("lit_t1_ready", 0, 32'(rdy[0]), 32'h4);
    tick(); req_valid = '0;
    @(negedge clk); chk("lit_t1_dpA", 0, 32'(dpa[0]), 32'd5); chk("lit_t1_dpB", 0, 32'(dpb[0]), 32'd3);
    @(negedge clk);
    chk("lit_t1_rv", 0, 32'(rv[0]), 32'h4); chk("lit_t1_Y", 0, 32'(ry[0]), 32'd8);
    chk("lit_t1_co", 0, 32'(rc[0]), 32'd0); chk("lit_t1_id", 0, 32'(rid[0]), 32'd2);
    @(negedge clk); chk("lit_t1_idle", 0, 32'(idl[0]), 32'd1);

    // ptr is now 3: requesters 1 and 2 valid
    tick(); set_op(1, 16'h1234, 16'h0001, OP_INC); set_op(2, 16'h00FF, 16'h0F00, OP_ADDC); req_valid = 4'b0110;
    @(negedge clk); chk("lit_t4_first", 0, 32'(rdy[0]), 32'h2);
    tick(); req_valid = 4'b0100;
    @(negedge clk); chk("lit_t4_second", 0, 32'(rdy[0]), 32'h4);
    tick(); req_valid = '0;

    // subtract on requester 0, checked on the LAT=1 instance
    set_op(0, 16'h0005, 16'h0003, OP_SUB); req_valid = 4'b0001;
    @(negedge clk); chk("lit_t2_ready", 1, 32'(rdy[1]), 32'h1);
    tick(); req_valid = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("lit_t2_rv", 1, 32'(rv[1]), 32'h1); chk("lit_t2_Y", 1, 32'(ry[1]), 32'h2); chk("lit_t2_co", 1, 32'(rc[1]), 32'd1);

    // enable dropped right after a grant
    tick(); set_op(1, 16'h00AA, 16'h0011, OP_DEC); req_valid = 4'b0010;
    @(negedge clk); chk("lit_t5_ready", 0, 32'(rdy[0]), 32'h2);
    tick(); en = 1'b0; req_valid = 4'b1010; set_op(3, 16'h0001, 16'h0002, OP_ADD);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lit_t5_gated", 0, 32'(rdy[0]), 32'd0);
      if (rv[0] == 4'b0010) pulses++;
    end
    chk("lit_t5_pulses", 0, 32'(pulses), 32'd1);
    tick(); en = 1'b1; req_valid = '0;

    // fairness after reset, all requesters continuously valid
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    for (int r = 0; r < R; r++) set_op(r, rnd(), rnd(), 3'($urandom_range(0, 7)));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("lit_t3_order", 0, 32'(rdy[0]), 32'(1) << (k % 4));
      tick(); set_op(k % 4, rnd(), rnd(), 3'($urandom_range(0, 7)));
    end
    req_valid = '0;
    repeat (6) tick();

    // reset with two ops in flight on the LAT=2 instance
    set_op(0, 16'h1111, 16'h2222, OP_ADD); req_valid = 4'b0001;
    @(negedge clk); tick();
    set_op(1, 16'h3333, 16'h0001, OP_SUB); req_valid = 4'b0010;
    @(negedge clk); tick();
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk); chk("lit_t6_idle", 2, 32'(idl[2]), 32'd1); chk("lit_t6_rv", 2, 32'(rv[2]), 32'd0);
    tick(); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk("lit_t6_quiet", 2, 32'(rv[2]), 32'd0);
    end
    tick(); req_valid = '1;
    @(negedge clk); chk("lit_t6_first", 0, 32'(rdy[0]), 32'h1);
    tick(); req_valid = '0;

    // random traffic: losers hold operands, winners may reload or drop
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); fire = req_valid & rdy[0];
      tick();
      en = ($urandom_range(0, 7) != 0);
      for (int r = 0; r < R; r++)
        if (fire[r] || !req_valid[r]) begin
          if ($urandom_range(0, 9) < 6) begin
            req_valid[r] = 1'b1;
            set_op(r, rnd(), rnd(), 3'($urandom_range(0, 7)));
          end else req_valid[r] = 1'b0;
        end
    end
    req_valid = '0;
    repeat (6) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
